// File: rtl/adda_pkg.sv
// Shared types and constants for the DDS control path: FSM states, ASCII codes
// and a helper that counts significant decimal digits in a packed BCD word.
package adda_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SEND,
    CR,
    LF
  } state_e;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int unsigned MAX_DIGITS = 20;

  // Number of digits up to and including the most significant nonzero one;
  // an all-zero word still counts as one digit so that "0" gets printed.
  function automatic int unsigned sig_digits(input logic [4*MAX_DIGITS-1:0] bcd);
    int unsigned n;
    n = 1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/freq_report_tx_bin2bcd.sv
// Iterative double-dabble converter: load latches a binary word, then each
// step consumes one bit MSB first; ready rises after WIDTH steps.
module bin2bcd #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ready
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [4*DIGITS-1:0] adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;

  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    adj     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    if (load) begin
      bin_d   = bin_in;
      bcd_d   = '0;
      cnt_d   = '0;
      ready_d = 1'b0;
    end else if (step && !ready_q) begin
      bin_d = bin_q << 1;
      bcd_d = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(WIDTH - 1)) ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign bcd_out = bcd_q;
  assign ready   = ready_q;

endmodule

// File: rtl/freq_report_tx.sv
// Reports a binary frequency word as ASCII decimal (leading zeros suppressed,
// optional CR LF) over a valid/ready byte interface to the UART transmitter.
module freq_report_tx
  import adda_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIGITS    = 10,
  parameter bit          SEND_CRLF = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e              state_q, state_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  logic                conv_load;
  logic                conv_step;
  logic                conv_ready;
  logic [4*DIGITS-1:0] bcd;
  logic [4*MAX_DIGITS-1:0] bcd_ext;
  logic [PTR_W-1:0]    sel_ptr;
  logic [3:0]          sel_digit;

  bin2bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (conv_load),
    .step    (conv_step),
    .bin_in  (value),
    .bcd_out (bcd),
    .ready   (conv_ready)
  );

  assign conv_load = (state_q == IDLE) && start;
  assign conv_step = (state_q == CONV);
  assign bcd_ext   = (4*MAX_DIGITS)'(bcd);

  // Digit to present next: the leading digit on CONV exit, else the one below the current.
  assign sel_ptr   = (state_q == CONV) ? PTR_W'(sig_digits(bcd_ext) - 1) : ptr_q - 1'b1;
  assign sel_digit = bcd[{sel_ptr, 2'b00} +: 4];

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ptr_d      = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (conv_ready) begin
          ptr_d      = sel_ptr;
          tx_data_d  = ASCII_0 + {4'd0, sel_digit};
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (ptr_q != '0) begin
            ptr_d     = sel_ptr;
            tx_data_d = ASCII_0 + {4'd0, sel_digit};
          end else if (SEND_CRLF) begin
            tx_data_d = ASCII_CR;
            state_d   = CR;
          end else begin
            tx_data_d  = '0;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      CR: begin
        if (tx_ready) begin
          tx_data_d = ASCII_LF;
          state_d   = LF;
        end
      end
      LF: begin
        if (tx_ready) begin
          tx_data_d  = '0;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ptr_q      <= ptr_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/freq_report_tx.md
# freq_report_tx

Serializes a binary frequency control word into ASCII decimal digits for the UART transmit path. It is the outbound counterpart of the digit parser that builds the DDS tuning word from received characters. A start pulse latches the value, converts it to BCD, and emits the digits most-significant first with leading zeros suppressed, followed by CR LF, over a valid/ready byte handshake into the UART transmitter. The block sits between the frequency register of the DDS top level and the UART TX byte interface.

## Interface
- WIDTH, 32, bit width of the binary value
- DIGITS, 10, number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH-1
- SEND_CRLF, 1, 1 = append 0x0D 0x0A after the digits; 0 = digits only
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only while idle
- value  input  WIDTH  binary word to report; latched on an accepted start
- tx_data  output  8  ASCII byte to the UART transmitter
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  UART transmitter accepts the byte this cycle
- busy  output  1  high from an accepted start until completion
- done  output  1  one-cycle pulse on the final byte handshake

## Operation
- Reset values: tx_data=0, tx_valid=0, busy=0, done=0, state=IDLE, all internal registers cleared.
- States: IDLE -> CONV -> SEND -> (CR -> LF when SEND_CRLF) -> IDLE.
- IDLE: start=1 latches value, clears the BCD register, sets busy=1 and goes to CONV.
- CONV: double-dabble, one value bit per cycle, MSB first. Each digit that is >=5 gets +3, then the digits shift left. Runs exactly WIDTH cycles.
- CONV exit: the digit pointer is set to the index of the most significant nonzero digit. If every digit is zero, the pointer is 0, so the value 0 sends one "0" (0x30).
- SEND: tx_data = 0x30 + digit[pointer] and tx_valid=1. On tx_valid&&tx_ready, the pointer decrements; after digit 0 is sent, go to CR, or to IDLE when SEND_CRLF=0.
- CR/LF: tx_data = 0x0D, then 0x0A, each held until its handshake.
- Handshake: once tx_valid rises, tx_data and tx_valid stay stable until tx_ready. tx_ready while tx_valid=0 is ignored.
- Completion: on the final handshake, done=1 for one cycle, busy=0 and tx_valid=0 on the same edge.
- start while busy is ignored. The latched value is unaffected by later changes on value.
- Reset mid-operation: all outputs return to reset values immediately. No partial byte is resumed.

## Timing
- start sampled high at edge 0: busy=1 after edge 0.
- CONV occupies edges 1..WIDTH. tx_valid=1 with the first digit after edge WIDTH+1.
- With tx_ready held at 1, each byte takes one cycle. An N-digit report takes N+2 handshake cycles with CRLF.
- done pulses after the edge of the last handshake. A new start is accepted on the following edge, at the earliest.
- No combinational path from start or tx_ready to tx_data. tx_valid is registered.

## Structure
- Shared package adda_pkg holds:
  - the state enum (IDLE, CONV, SEND, CR, LF);
  - ASCII constants (ASCII_0=0x30, ASCII_CR=0x0D, ASCII_LF=0x0A);
  - a digit-count helper function.
- Sub-module bin2bcd holds the iterative double-dabble engine (load, step, BCD out, ready flag). It is reusable for future display output.
- The top level of freq_report_tx contains the FSM, the digit pointer and the handshake register.

## Test plan
- value=85899, start, tx_ready=1 -> bytes 0x38 0x35 0x38 0x39 0x39 0x0D 0x0A in consecutive cycles; done once; first tx_valid at edge 33.
- value=0 -> 0x30 0x0D 0x0A; value=4294967295 -> "4294967295" (0x34 … 0x35) then CR LF.
- tx_ready toggled randomly, with 5-cycle low stretches -> tx_data is stable while tx_valid&&!tx_ready; the byte sequence is unchanged and there are no duplicates.
- start pulsed with value=7 during a report of value=1000 -> output is "1000\r\n" only; value is changed mid-CONV with no effect.
- rst_n low for 1 cycle during the third digit of 85899 -> tx_valid=0 and busy=0 immediately; a new start for 12 gives "12\r\n".
- SEND_CRLF=0 build, value=60 -> 0x36 0x30 only, with done on the 0x30 handshake.
